// File: rtl/io_map_pkg.sv
// Shared IO window map: base address, register indices and CTRL bit positions.
package io_map_pkg;

    localparam logic [31:0] IO_BASE = 32'h0000_7FF0;

    typedef enum logic [1:0] {
        REG_LED   = 2'd0,
        REG_SW    = 2'd1,
        REG_COUNT = 2'd2,
        REG_CTRL  = 2'd3
    } io_reg_e;

    localparam int unsigned CTRL_EN      = 0;
    localparam int unsigned CTRL_AUTO    = 1;
    localparam int unsigned CTRL_IE      = 2;
    localparam int unsigned CTRL_EXPIRED = 8;

    // Assemble the CTRL readback word from its individual flags.
    function automatic logic [31:0] ctrl_word(
        input logic expired,
        input logic ie,
        input logic auto_rl,
        input logic en
    );
        logic [31:0] w;
        w               = '0;
        w[CTRL_EXPIRED] = expired;
        w[CTRL_IE]      = ie;
        w[CTRL_AUTO]    = auto_rl;
        w[CTRL_EN]      = en;
        return w;
    endfunction

endpackage

// File: rtl/io_prescaler.sv
// Divides the clock down to a one-cycle tick every PRESCALE cycles while enabled.
module io_prescaler #(
    parameter int unsigned PRESCALE = 10000
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic en_i,
    input  logic clr_i,
    output logic tick_o
);

    localparam int unsigned      CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(PRESCALE - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign tick_o = en_i && (cnt_q == LAST);

    // Wrap on tick; park at zero while disabled or when the owner restarts the period.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i || !en_i || tick_o) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Prescale counter register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/io_timer_peripheral.sv
// IO window responder: LED register, synchronised switches, auto-reload down-counter timer.
import io_map_pkg::*;

module io_timer_peripheral #(
    parameter int unsigned PRESCALE = 10000,
    parameter int unsigned LED_W    = 8,
    parameter int unsigned SW_W     = 8
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic [3:0]       IOAddr,
    input  logic [31:0]      IOWriteData,
    input  logic             IOWriteEn,
    output logic [31:0]      IOReadData,
    input  logic [SW_W-1:0]  Switches,
    output logic [LED_W-1:0] LED,
    output logic             IRQ
);

    io_reg_e sel;
    logic    wr_led;
    logic    wr_count;
    logic    wr_ctrl;
    logic    tick;
    logic    expire;
    logic    unused_addr_lsb;

    logic [LED_W-1:0] led_q, led_d;
    logic [SW_W-1:0]  sw_meta_q, sw_sync_q;
    logic [31:0]      count_q, count_d;
    logic [31:0]      reload_q, reload_d;
    logic             en_q, en_d;
    logic             auto_q, auto_d;
    logic             ie_q, ie_d;
    logic             expired_q, expired_d;

    // Byte offset within the word is irrelevant to register selection.
    assign unused_addr_lsb = ^IOAddr[1:0];

    assign sel      = io_reg_e'(IOAddr[3:2]);
    assign wr_led   = IOWriteEn && (sel == REG_LED);
    assign wr_count = IOWriteEn && (sel == REG_COUNT);
    assign wr_ctrl  = IOWriteEn && (sel == REG_CTRL);

    io_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clk_i  (CLK),
        .rst_i  (RESET),
        .en_i   (en_q),
        .clr_i  (wr_count),
        .tick_o (tick)
    );

    // Next-state for registers and timer; CPU writes override concurrent timer updates.
    always_comb begin
        led_d     = led_q;
        count_d   = count_q;
        reload_d  = reload_q;
        en_d      = en_q;
        auto_d    = auto_q;
        ie_d      = ie_q;
        expired_d = expired_q;
        expire    = 1'b0;

        if (wr_led) begin
            led_d = IOWriteData[LED_W-1:0];
        end

        if (wr_count) begin
            count_d  = IOWriteData;
            reload_d = IOWriteData;
        end else if (tick) begin
            if (count_q > 32'd1) begin
                count_d = count_q - 32'd1;
            end else begin
                expire = 1'b1;
                if (auto_q) begin
                    count_d = reload_q;
                end else begin
                    count_d = '0;
                    en_d    = 1'b0;
                end
            end
        end

        if (wr_ctrl) begin
            en_d   = IOWriteData[CTRL_EN];
            auto_d = IOWriteData[CTRL_AUTO];
            ie_d   = IOWriteData[CTRL_IE];
            if (IOWriteData[CTRL_EXPIRED]) begin
                expired_d = 1'b0;
            end
        end

        // An expiry in the same cycle as a clear must not be lost.
        if (expire) begin
            expired_d = 1'b1;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            led_q     <= '0;
            sw_meta_q <= '0;
            sw_sync_q <= '0;
            count_q   <= '0;
            reload_q  <= '0;
            en_q      <= 1'b0;
            auto_q    <= 1'b0;
            ie_q      <= 1'b0;
            expired_q <= 1'b0;
        end else begin
            led_q     <= led_d;
            sw_meta_q <= Switches;
            sw_sync_q <= sw_meta_q;
            count_q   <= count_d;
            reload_q  <= reload_d;
            en_q      <= en_d;
            auto_q    <= auto_d;
            ie_q      <= ie_d;
            expired_q <= expired_d;
        end
    end

    // Zero-latency read mux; every offset maps to a register.
    always_comb begin
        IOReadData = '0;
        case (sel)
            REG_LED:   IOReadData = 32'(led_q);
            REG_SW:    IOReadData = 32'(sw_sync_q);
            REG_COUNT: IOReadData = count_q;
            default:   IOReadData = ctrl_word(expired_q, ie_q, auto_q, en_q);
        endcase
    end

    assign LED = led_q;
    assign IRQ = expired_q & ie_q;

endmodule

// File: tb/tb_io_timer_peripheral.sv
// Self-checking bench for io_timer_peripheral with a behavioural reference model.
module tb_io_timer_peripheral;

    localparam int unsigned P = 4;

    logic        CLK = 1'b0;
    logic        RESET;
    logic [3:0]  IOAddr;
    logic [31:0] IOWriteData;
    logic        IOWriteEn;
    logic [31:0] IOReadData;
    logic [7:0]  Switches;
    logic [7:0]  LED;
    logic        IRQ;

    int total = 0;
    int bad   = 0;

    // Reference model state
    logic [7:0]  m_led, m_sw1, m_sw2;
    logic [31:0] m_count, m_reload;
    logic        m_en, m_auto, m_ie, m_exp;
    int unsigned m_phase;

    io_timer_peripheral #(
        .PRESCALE (P),
        .LED_W    (8),
        .SW_W     (8)
    ) dut (
        .CLK         (CLK),
        .RESET       (RESET),
        .IOAddr      (IOAddr),
        .IOWriteData (IOWriteData),
        .IOWriteEn   (IOWriteEn),
        .IOReadData  (IOReadData),
        .Switches    (Switches),
        .LED         (LED),
        .IRQ         (IRQ)
    );

    always #5 CLK = ~CLK;

    initial begin
        #1000000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    function automatic logic [31:0] model_read(input logic [3:0] a);
        case (a[3:2])
            2'd0:    return {24'b0, m_led};
            2'd1:    return {24'b0, m_sw2};
            2'd2:    return m_count;
            default: return {23'b0, m_exp, 5'b0, m_ie, m_auto, m_en};
        endcase
    endfunction

    // Advance one clock: model computes the post-edge state from the current inputs.
    task automatic cyc();
        logic [1:0]  sel;
        logic        wl, wc, wt, tick, fire;
        logic [7:0]  n_led, n_sw1, n_sw2;
        logic [31:0] n_count, n_reload;
        logic        n_en, n_auto, n_ie, n_exp;
        int unsigned n_phase;
        sel  = IOAddr[3:2];
        wl   = IOWriteEn && (sel == 2'd0);
        wc   = IOWriteEn && (sel == 2'd2);
        wt   = IOWriteEn && (sel == 2'd3);
        tick = m_en && (((m_phase + 1) % P) == 0);
        n_led = wl ? IOWriteData[7:0] : m_led;
        n_sw1 = Switches;
        n_sw2 = m_sw1;
        n_count = m_count; n_reload = m_reload;
        n_en = m_en; n_auto = m_auto; n_ie = m_ie; n_exp = m_exp;
        fire = 1'b0;
        n_phase = m_en ? (m_phase + 1) % P : 0;
        if (wc) begin
            n_count = IOWriteData; n_reload = IOWriteData; n_phase = 0;
        end else if (tick) begin
            if (m_count >= 2) n_count = m_count - 1;
            else begin
                fire = 1'b1;
                n_count = m_auto ? m_reload : 32'd0;
                if (!m_auto) n_en = 1'b0;
            end
        end
        if (wt) begin
            n_en = IOWriteData[0]; n_auto = IOWriteData[1]; n_ie = IOWriteData[2];
            if (IOWriteData[8]) n_exp = 1'b0;
        end
        if (fire) n_exp = 1'b1;
        if (RESET) begin
            n_led = '0; n_sw1 = '0; n_sw2 = '0; n_count = '0; n_reload = '0;
            n_en = 0; n_auto = 0; n_ie = 0; n_exp = 0; n_phase = 0;
        end
        @(posedge CLK);
        #1;
        m_led = n_led; m_sw1 = n_sw1; m_sw2 = n_sw2; m_count = n_count; m_reload = n_reload;
        m_en = n_en; m_auto = n_auto; m_ie = n_ie; m_exp = n_exp; m_phase = n_phase;
    endtask

    task automatic idle(input int n);
        IOWriteEn = 1'b0;
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d);
        IOAddr = a; IOWriteData = d; IOWriteEn = 1'b1;
        cyc();
        IOWriteEn = 1'b0;
    endtask

    task automatic peek(input logic [3:0] a, output logic [31:0] d);
        IOAddr = a;
        #1;
        d = IOReadData;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        RESET = 1'b1; IOWriteEn = 1'b0; IOAddr = '0; IOWriteData = '0; Switches = 8'hA5;
        cyc(); cyc();
        RESET = 1'b0;
        for (int i = 0; i < 4; i++) begin
            peek(4'(i * 4), d);
            total++;
            if (d !== 32'h0) begin bad++; $display("FAIL reset_read[%0d] got=%h want=0", i, d); end
        end
        total++;
        if (LED !== 8'h0 || IRQ !== 1'b0) begin
            bad++; $display("FAIL reset_outs got LED=%h IRQ=%b want 0/0", LED, IRQ);
        end
        idle(2);
        peek(4'h4, d);
        total++;
        if (d !== 32'hA5) begin bad++; $display("FAIL sw_sync got=%h want=000000a5", d); end
    endtask

    task automatic test_led_switch();
        logic [31:0] d;
        logic [7:0]  sv;
        wr(4'h0, 32'h1234_56C3);
        total++;
        if (LED !== 8'hC3) begin bad++; $display("FAIL led_out got=%h want=c3", LED); end
        peek(4'h0, d);
        total++;
        if (d !== 32'h0000_00C3) begin bad++; $display("FAIL led_read got=%h want=000000c3", d); end
        wr(4'h4, 32'hFFFF_FFFF);
        peek(4'h4, d);
        total++;
        if (d !== 32'hA5) begin bad++; $display("FAIL sw_write_ignored got=%h want=000000a5", d); end
        sv = 8'($urandom_range(0, 255)) ^ 8'hA5;
        if (sv == 8'hA5) sv = 8'h3C;
        Switches = sv;
        idle(1);
        peek(4'h4, d);
        total++;
        if (d !== 32'hA5) begin bad++; $display("FAIL sw_one_flop got=%h want=000000a5", d); end
        idle(1);
        peek(4'h4, d);
        total++;
        if (d !== {24'b0, sv}) begin bad++; $display("FAIL sw_two_flop got=%h want=%h", d, {24'b0, sv}); end
    endtask

    task automatic test_oneshot();
        logic [31:0] d, want;
        wr(4'h8, 32'd3);
        wr(4'hC, 32'h5);
        for (int c = 1; c <= 12; c++) begin
            idle(1);
            want = (c < 4) ? 32'd3 : (c < 8) ? 32'd2 : (c < 12) ? 32'd1 : 32'd0;
            peek(4'h8, d);
            total++;
            if (d !== want) begin bad++; $display("FAIL oneshot_count c=%0d got=%h want=%h", c, d, want); end
        end
        peek(4'hC, d);
        total++;
        if (d !== 32'h104 || IRQ !== 1'b1) begin
            bad++; $display("FAIL oneshot_expire got ctrl=%h IRQ=%b want 00000104/1", d, IRQ);
        end
        idle(20);
        peek(4'h8, d);
        total++;
        if (d !== 32'd0) begin bad++; $display("FAIL oneshot_hold got=%h want=0", d); end
    endtask

    task automatic test_autoreload();
        logic [31:0] d, want;
        wr(4'hC, 32'h100);
        wr(4'h8, 32'd2);
        wr(4'hC, 32'h3);
        for (int c = 1; c <= 16; c++) begin
            idle(1);
            want = (((c / 4) % 2) == 1) ? 32'd1 : 32'd2;
            peek(4'h8, d);
            total++;
            if (d !== want) begin bad++; $display("FAIL auto_count c=%0d got=%h want=%h", c, d, want); end
        end
        peek(4'hC, d);
        total++;
        if (d !== 32'h103 || IRQ !== 1'b0) begin
            bad++; $display("FAIL auto_flags got ctrl=%h IRQ=%b want 00000103/0", d, IRQ);
        end
        wr(4'hC, 32'h103);
        peek(4'hC, d);
        total++;
        if (d !== 32'h003) begin bad++; $display("FAIL auto_clear got=%h want=00000003", d); end
        idle(3);
        peek(4'h8, d);
        total++;
        if (d !== 32'd1) begin bad++; $display("FAIL auto_continue got=%h want=1", d); end
    endtask

    task automatic test_collisions();
        logic [31:0] d;
        wr(4'hC, 32'h100);
        wr(4'h8, 32'd1);
        wr(4'hC, 32'h107);
        idle(4);
        peek(4'hC, d);
        total++;
        if (d !== 32'h107 || IRQ !== 1'b1) begin bad++; $display("FAIL col_first got ctrl=%h IRQ=%b want 00000107/1", d, IRQ); end
        wr(4'hC, 32'h107);
        peek(4'hC, d);
        total++;
        if (d !== 32'h007 || IRQ !== 1'b0) begin bad++; $display("FAIL col_clear got ctrl=%h IRQ=%b want 00000007/0", d, IRQ); end
        idle(2);
        wr(4'hC, 32'h107);
        peek(4'hC, d);
        total++;
        if (d !== 32'h107 || IRQ !== 1'b1) begin bad++; $display("FAIL col_clear_vs_expire got ctrl=%h IRQ=%b want 00000107/1", d, IRQ); end
        idle(3);
        wr(4'h8, 32'd9);
        peek(4'h8, d);
        total++;
        if (d !== 32'd9) begin bad++; $display("FAIL col_count_vs_tick got=%h want=9", d); end
        idle(3);
        peek(4'h8, d);
        total++;
        if (d !== 32'd9) begin bad++; $display("FAIL col_prescale_restart got=%h want=9", d); end
        idle(1);
        peek(4'h8, d);
        total++;
        if (d !== 32'd8) begin bad++; $display("FAIL col_next_tick got=%h want=8", d); end
        // EN write versus one-shot auto-clear
        wr(4'hC, 32'h100);
        wr(4'h8, 32'd1);
        wr(4'hC, 32'h5);
        idle(3);
        wr(4'hC, 32'h5);
        peek(4'hC, d);
        total++;
        if (d !== 32'h105) begin bad++; $display("FAIL col_en_write_wins got=%h want=00000105", d); end
        idle(4);
        peek(4'hC, d);
        total++;
        if (d !== 32'h104 || IRQ !== 1'b1) begin bad++; $display("FAIL col_zero_count got ctrl=%h IRQ=%b want 00000104/1", d, IRQ); end
    endtask

    task automatic test_reset_midcount();
        logic [31:0] d;
        wr(4'hC, 32'h100);
        wr(4'h8, 32'd5);
        wr(4'hC, 32'h5);
        idle(2);
        RESET = 1'b1;
        cyc();
        RESET = 1'b0;
        for (int i = 0; i < 4; i++) begin
            peek(4'(i * 4), d);
            total++;
            if (d !== 32'h0) begin bad++; $display("FAIL midreset_read[%0d] got=%h want=0", i, d); end
        end
        total++;
        if (LED !== 8'h0 || IRQ !== 1'b0) begin bad++; $display("FAIL midreset_outs got LED=%h IRQ=%b want 0/0", LED, IRQ); end
        idle(6);
        peek(4'h8, d);
        total++;
        if (d !== 32'h0) begin bad++; $display("FAIL midreset_no_tick got=%h want=0", d); end
        peek(4'h4, d);
        total++;
        if (d !== {24'b0, Switches}) begin bad++; $display("FAIL midreset_sw got=%h want=%h", d, {24'b0, Switches}); end
    endtask

    // Random bus traffic; reads sampled before the edge see pre-write values.
    task automatic test_random();
        logic [31:0] want;
        logic [31:0] wd;
        for (int it = 0; it < 400; it++) begin
            IOAddr    = 4'($urandom_range(0, 15));
            IOWriteEn = ($urandom_range(0, 3) == 0);
            case (IOAddr[3:2])
                2'd2:    wd = 32'($urandom_range(0, 5));
                2'd3:    wd = {23'b0, 1'($urandom_range(0, 1)), 5'b0, 3'($urandom_range(0, 7)) | 3'($urandom_range(0, 1))};
                default: wd = $urandom;
            endcase
            IOWriteData = wd;
            RESET = ($urandom_range(0, 99) == 0);
            if ($urandom_range(0, 15) == 0) Switches = 8'($urandom_range(0, 255));
            #1;
            want = model_read(IOAddr);
            total++;
            if (IOReadData !== want) begin bad++; $display("FAIL rand_read it=%0d addr=%h got=%h want=%h", it, IOAddr, IOReadData, want); end
            total++;
            if (LED !== m_led) begin bad++; $display("FAIL rand_led it=%0d got=%h want=%h", it, LED, m_led); end
            total++;
            if (IRQ !== (m_exp & m_ie)) begin bad++; $display("FAIL rand_irq it=%0d got=%b want=%b", it, IRQ, m_exp & m_ie); end
            cyc();
        end
        RESET = 1'b0;
        IOWriteEn = 1'b0;
    endtask

    initial begin
        m_led = '0; m_sw1 = '0; m_sw2 = '0; m_count = '0; m_reload = '0;
        m_en = 0; m_auto = 0; m_ie = 0; m_exp = 0; m_phase = 0;
        RESET = 1'b1; IOWriteEn = 1'b0; IOAddr = '0; IOWriteData = '0; Switches = '0;
        #2;
        test_reset();
        test_led_switch();
        test_oneshot();
        test_autoreload();
        test_collisions();
        test_reset_midcount();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
